// File: rtl/rgb_pwm_sequencer_if.sv
// Config channel for rgb_pwm_sequencer: one valid/ready offer carrying
// the colour mode and the three per-channel duties.
interface rgb_pwm_sequencer_if #(
  parameter int PWM_BITS = 8
);
  logic                cfg_valid;
  logic                cfg_ready;
  logic [1:0]          cfg_mode;
  logic [PWM_BITS-1:0] cfg_red;
  logic [PWM_BITS-1:0] cfg_green;
  logic [PWM_BITS-1:0] cfg_blue;

  modport master (
    output cfg_valid, cfg_mode, cfg_red, cfg_green, cfg_blue,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid, cfg_mode, cfg_red, cfg_green, cfg_blue,
    output cfg_ready
  );
endinterface

// File: rtl/rgb_pwm_sequencer.sv
// PWM/enable generator for the iCE40 RGB LED driver with off/solid/blink/
// breathe modes; new colour settings are shadowed until the end of a PWM period.
module rgb_pwm_sequencer #(
  parameter int PWM_BITS    = 8,
  parameter int STEP_DIV    = 120000,
  parameter int BLINK_STEPS = 50
) (
  input  logic                 hw_clk,
  input  logic                 rst_n,
  rgb_pwm_sequencer_if.slave   cfg,
  output logic                 pwm_red,
  output logic                 pwm_green,
  output logic                 pwm_blue,
  output logic                 led_en,
  output logic                 phase
);

  localparam int SW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam int BW = (BLINK_STEPS > 1) ? $clog2(BLINK_STEPS) : 1;
  localparam logic [PWM_BITS-1:0] CNT_MAX    = '1;
  localparam logic [SW-1:0]       STEP_LAST  = SW'(STEP_DIV - 1);
  localparam logic [BW-1:0]       BLINK_LAST = BW'(BLINK_STEPS - 1);

  typedef enum logic [1:0] {MODE_OFF, MODE_SOLID, MODE_BLINK, MODE_BREATHE} mode_e;
  typedef enum logic {RAMP_UP, RAMP_DOWN} breathe_e;

  logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
  logic                shd_vld_q, shd_vld_d;
  mode_e               shd_mode_q, shd_mode_d;
  logic [PWM_BITS-1:0] shd_red_q, shd_red_d, shd_green_q, shd_green_d, shd_blue_q, shd_blue_d;
  mode_e               act_mode_q, act_mode_d;
  logic [PWM_BITS-1:0] act_red_q, act_red_d, act_green_q, act_green_d, act_blue_q, act_blue_d;
  logic [SW-1:0]       step_cnt_q, step_cnt_d;
  logic [BW-1:0]       blink_cnt_q, blink_cnt_d;
  logic                blink_on_q, blink_on_d;
  logic [PWM_BITS-1:0] level_q, level_d;
  breathe_e            br_state_q, br_state_d;
  logic                pwm_red_q, pwm_red_d, pwm_green_q, pwm_green_d, pwm_blue_q, pwm_blue_d;
  logic                led_en_q, led_en_d, phase_q, phase_d;

  logic apply_pt, xfer, load, tick;
  logic [PWM_BITS-1:0] eff_red, eff_green, eff_blue;

  // Truncating (duty * level) >> PWM_BITS over the full double-width product.
  function automatic logic [PWM_BITS-1:0] breathe_scale(input logic [PWM_BITS-1:0] duty,
                                                        input logic [PWM_BITS-1:0] lvl);
    logic [2*PWM_BITS-1:0] prod;
    prod = {{PWM_BITS{1'b0}}, duty} * {{PWM_BITS{1'b0}}, lvl};
    return prod[2*PWM_BITS-1:PWM_BITS];
  endfunction

  function automatic logic [PWM_BITS-1:0] eff_duty(input mode_e m, input logic on,
                                                   input logic [PWM_BITS-1:0] duty,
                                                   input logic [PWM_BITS-1:0] lvl);
    case (m)
      MODE_SOLID:   return duty;
      MODE_BLINK:   return on ? duty : '0;
      MODE_BREATHE: return breathe_scale(duty, lvl);
      default:      return '0;
    endcase
  endfunction

  assign cfg.cfg_ready = ~shd_vld_q;
  assign apply_pt      = (pwm_cnt_q == CNT_MAX);
  assign xfer          = cfg.cfg_valid & ~shd_vld_q;
  assign load          = apply_pt & (xfer | shd_vld_q);
  assign tick          = (step_cnt_q == STEP_LAST);

  always_comb begin
    pwm_cnt_d   = pwm_cnt_q + PWM_BITS'(1);
    shd_vld_d   = shd_vld_q;
    shd_mode_d  = shd_mode_q;
    shd_red_d   = shd_red_q;
    shd_green_d = shd_green_q;
    shd_blue_d  = shd_blue_q;
    act_mode_d  = act_mode_q;
    act_red_d   = act_red_q;
    act_green_d = act_green_q;
    act_blue_d  = act_blue_q;
    step_cnt_d  = tick ? '0 : step_cnt_q + SW'(1);
    blink_cnt_d = blink_cnt_q;
    blink_on_d  = blink_on_q;

    // A transfer landing on the apply point bypasses the shadow entirely.
    if (xfer && !apply_pt) begin
      shd_vld_d   = 1'b1;
      shd_mode_d  = mode_e'(cfg.cfg_mode);
      shd_red_d   = cfg.cfg_red;
      shd_green_d = cfg.cfg_green;
      shd_blue_d  = cfg.cfg_blue;
    end
    if (apply_pt) shd_vld_d = 1'b0;
    if (load) begin
      act_mode_d  = xfer ? mode_e'(cfg.cfg_mode) : shd_mode_q;
      act_red_d   = xfer ? cfg.cfg_red   : shd_red_q;
      act_green_d = xfer ? cfg.cfg_green : shd_green_q;
      act_blue_d  = xfer ? cfg.cfg_blue  : shd_blue_q;
    end

    if (tick && act_mode_q == MODE_BLINK) begin
      if (blink_cnt_q == BLINK_LAST) begin
        blink_cnt_d = '0;
        blink_on_d  = ~blink_on_q;
      end else begin
        blink_cnt_d = blink_cnt_q + BW'(1);
      end
    end

    if (load) begin
      step_cnt_d  = '0;
      blink_cnt_d = '0;
      blink_on_d  = 1'b1;
    end
  end

  always_comb begin
    level_d    = level_q;
    br_state_d = br_state_q;
    if (tick && act_mode_q == MODE_BREATHE) begin
      case (br_state_q)
        RAMP_UP: begin
          level_d = level_q + PWM_BITS'(1);
          if (level_q == CNT_MAX - PWM_BITS'(1)) br_state_d = RAMP_DOWN;
        end
        default: begin
          level_d = level_q - PWM_BITS'(1);
          if (level_q == PWM_BITS'(1)) br_state_d = RAMP_UP;
        end
      endcase
    end
    if (load) begin
      level_d    = '0;
      br_state_d = RAMP_UP;
    end
  end

  always_comb begin
    eff_red     = eff_duty(act_mode_q, blink_on_q, act_red_q,   level_q);
    eff_green   = eff_duty(act_mode_q, blink_on_q, act_green_q, level_q);
    eff_blue    = eff_duty(act_mode_q, blink_on_q, act_blue_q,  level_q);
    pwm_red_d   = (pwm_cnt_q < eff_red);
    pwm_green_d = (pwm_cnt_q < eff_green);
    pwm_blue_d  = (pwm_cnt_q < eff_blue);
    led_en_d    = (act_mode_q != MODE_OFF);
    case (act_mode_q)
      MODE_BLINK:   phase_d = blink_on_q;
      MODE_BREATHE: phase_d = (br_state_q == RAMP_UP);
      default:      phase_d = 1'b0;
    endcase
  end

  always_ff @(posedge hw_clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_cnt_q   <= '0;
      shd_vld_q   <= 1'b0;
      shd_mode_q  <= MODE_OFF;
      shd_red_q   <= '0;
      shd_green_q <= '0;
      shd_blue_q  <= '0;
      act_mode_q  <= MODE_OFF;
      act_red_q   <= '0;
      act_green_q <= '0;
      act_blue_q  <= '0;
      step_cnt_q  <= '0;
      blink_cnt_q <= '0;
      blink_on_q  <= 1'b1;
      level_q     <= '0;
      br_state_q  <= RAMP_UP;
      pwm_red_q   <= 1'b0;
      pwm_green_q <= 1'b0;
      pwm_blue_q  <= 1'b0;
      led_en_q    <= 1'b0;
      phase_q     <= 1'b0;
    end else begin
      pwm_cnt_q   <= pwm_cnt_d;
      shd_vld_q   <= shd_vld_d;
      shd_mode_q  <= shd_mode_d;
      shd_red_q   <= shd_red_d;
      shd_green_q <= shd_green_d;
      shd_blue_q  <= shd_blue_d;
      act_mode_q  <= act_mode_d;
      act_red_q   <= act_red_d;
      act_green_q <= act_green_d;
      act_blue_q  <= act_blue_d;
      step_cnt_q  <= step_cnt_d;
      blink_cnt_q <= blink_cnt_d;
      blink_on_q  <= blink_on_d;
      level_q     <= level_d;
      br_state_q  <= br_state_d;
      pwm_red_q   <= pwm_red_d;
      pwm_green_q <= pwm_green_d;
      pwm_blue_q  <= pwm_blue_d;
      led_en_q    <= led_en_d;
      phase_q     <= phase_d;
    end
  end

  assign pwm_red   = pwm_red_q;
  assign pwm_green = pwm_green_q;
  assign pwm_blue  = pwm_blue_q;
  assign led_en    = led_en_q;
  assign phase     = phase_q;

endmodule

// File: tb/tb_rgb_pwm_sequencer.sv
// Bench for rgb_pwm_sequencer: a schedule of accepted configs drives a
// time-based model of every output, compared once per clock.
module tb_rgb_pwm_sequencer;

  localparam int PB   = 4;
  localparam int SD   = 4;
  localparam int BS   = 2;
  localparam int PER  = 16;
  localparam int MAXL = 15;

  logic hw_clk = 1'b0;
  logic rst_n  = 1'b0;
  logic pwm_red, pwm_green, pwm_blue, led_en, phase;

  rgb_pwm_sequencer_if #(.PWM_BITS(PB)) cfg_if ();

  rgb_pwm_sequencer #(.PWM_BITS(PB), .STEP_DIV(SD), .BLINK_STEPS(BS)) dut (
    .hw_clk   (hw_clk),
    .rst_n    (rst_n),
    .cfg      (cfg_if),
    .pwm_red  (pwm_red),
    .pwm_green(pwm_green),
    .pwm_blue (pwm_blue),
    .led_en   (led_en),
    .phase    (phase)
  );

  always #5 hw_clk = ~hw_clk;

  // Clocks since reset release; the DUT's PWM counter equals cyc mod 16.
  int cyc;
  always @(posedge hw_clk or negedge rst_n)
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;

  typedef struct {
    int n;     // cycle the transfer happened
    int a;     // apply-point cycle
    int mode;
    int r;
    int g;
    int b;
  } cfg_t;

  cfg_t sched[$];
  int total  = 0;
  int passed = 0;

  function automatic int eff_of(input int mode, input int d, input int j);
    int n, t, lvl;
    case (mode)
      1: return d;
      2: return ((j / (SD * BS)) % 2 == 0) ? d : 0;
      3: begin
        n = j / SD;
        t = n % (2 * MAXL);
        lvl = (t <= MAXL) ? t : (2 * MAXL - t);
        return (d * lvl) >> PB;
      end
      default: return 0;
    endcase
  endfunction

  // {ready, led_en, phase, blue, green, red} seen after the edge ending cycle c-1.
  function automatic logic [5:0] model_out(input int c);
    int mode = 0, r = 0, g = 0, b = 0, a = -100, j;
    logic rdy = 1'b1, ph = 1'b0, pr, pg, pbl;
    foreach (sched[i]) begin
      if (sched[i].a + 2 <= c) begin
        mode = sched[i].mode; a = sched[i].a;
        r = sched[i].r; g = sched[i].g; b = sched[i].b;
      end
      if (sched[i].n < c && c <= sched[i].a) rdy = 1'b0;
    end
    j = c - a - 2;
    if (mode == 2) ph = ((j / (SD * BS)) % 2 == 0);
    if (mode == 3) ph = (((j / SD) % (2 * MAXL)) < MAXL);
    pr  = (mode != 0) && ((j % PER) < eff_of(mode, r, j));
    pg  = (mode != 0) && ((j % PER) < eff_of(mode, g, j));
    pbl = (mode != 0) && ((j % PER) < eff_of(mode, b, j));
    return {rdy, (mode != 0), ph, pbl, pg, pr};
  endfunction

  task automatic step();
    @(posedge hw_clk);
    #1;
  endtask

  task automatic wait_cnt(input int k);
    int guard = 0;
    while ((cyc % PER) != k && guard < 64) begin
      step();
      guard++;
    end
  endtask

  task automatic do_config(input int m, input int r, input int g, input int b);
    int guard = 0;
    cfg_t e;
    while (cfg_if.cfg_ready !== 1'b1 && guard < 200) begin
      step();
      guard++;
    end
    if (cfg_if.cfg_ready !== 1'b1) begin
      total++;
      $display("FAIL ready_timeout cyc=%0d cfg_ready=%b required=1", cyc, cfg_if.cfg_ready);
    end else begin
      cfg_if.cfg_valid = 1'b1;
      cfg_if.cfg_mode  = 2'(m);
      cfg_if.cfg_red   = PB'(r);
      cfg_if.cfg_green = PB'(g);
      cfg_if.cfg_blue  = PB'(b);
      e.n = cyc; e.a = cyc + (MAXL - cyc % PER);
      e.mode = m; e.r = r; e.g = g; e.b = b;
      sched.push_back(e);
      step();
      cfg_if.cfg_valid = 1'b0;
    end
  endtask

  task automatic test_reset();
    logic [5:0] got, exp;
    rst_n = 1'b0;
    cfg_if.cfg_valid = 1'b0;
    cfg_if.cfg_mode = '0; cfg_if.cfg_red = '0; cfg_if.cfg_green = '0; cfg_if.cfg_blue = '0;
    sched.delete();
    repeat (5) step();
    got = {cfg_if.cfg_ready, led_en, phase, pwm_blue, pwm_green, pwm_red};
    total++;
    if (got !== 6'b100000) $display("FAIL reset_hold got=%b required=100000", got);
    else passed++;
    @(negedge hw_clk);
    rst_n = 1'b1;
    for (int i = 0; i < 64; i++) begin
      step();
      got = {cfg_if.cfg_ready, led_en, phase, pwm_blue, pwm_green, pwm_red};
      exp = model_out(cyc);
      total++;
      if (got !== exp || got !== 6'b100000)
        $display("FAIL reset_idle cyc=%0d got=%b required=100000", cyc, got);
      else passed++;
    end
  endtask

  task automatic test_solid();
    logic [5:0] got, exp;
    int cr = 0, cg = 0, cb = 0;
    do_config(1, 5, 0, 15);
    for (int i = 0; i < 48; i++) begin
      step();
      got = {cfg_if.cfg_ready, led_en, phase, pwm_blue, pwm_green, pwm_red};
      exp = model_out(cyc);
      total++;
      if (got !== exp) $display("FAIL solid cyc=%0d got=%b required=%b", cyc, got, exp);
      else passed++;
    end
    for (int i = 0; i < PER; i++) begin
      step();
      cr += int'(pwm_red); cg += int'(pwm_green); cb += int'(pwm_blue);
    end
    total++;
    if (cr != 5 || cg != 0 || cb != 15 || led_en !== 1'b1)
      $display("FAIL solid_counts got r=%0d g=%0d b=%0d en=%b required r=5 g=0 b=15 en=1", cr, cg, cb, led_en);
    else passed++;
  endtask

  task automatic test_handshake();
    logic [5:0] got, exp;
    int a2, guard;
    cfg_t e;
    wait_cnt(3);
    do_config(1, 9, 3, 12);
    a2 = sched[$].a;
    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_mode  = 2'd2;
    cfg_if.cfg_red   = PB'($urandom_range(15));
    cfg_if.cfg_green = PB'($urandom_range(15));
    cfg_if.cfg_blue  = PB'($urandom_range(15));
    guard = 0;
    while (cyc <= a2 && guard < 40) begin
      got = {cfg_if.cfg_ready, led_en, phase, pwm_blue, pwm_green, pwm_red};
      exp = model_out(cyc);
      total++;
      if (got !== exp || cfg_if.cfg_ready !== 1'b0)
        $display("FAIL hs_window cyc=%0d got=%b required=%b", cyc, got, exp);
      else passed++;
      step();
      guard++;
    end
    e.n = cyc; e.a = cyc + (MAXL - cyc % PER); e.mode = 2;
    e.r = int'(cfg_if.cfg_red); e.g = int'(cfg_if.cfg_green); e.b = int'(cfg_if.cfg_blue);
    sched.push_back(e);
    got = {cfg_if.cfg_ready, led_en, phase, pwm_blue, pwm_green, pwm_red};
    exp = model_out(cyc);
    total++;
    if (got !== exp || cfg_if.cfg_ready !== 1'b1)
      $display("FAIL hs_reopen cyc=%0d got=%b required=%b", cyc, got, exp);
    else passed++;
    step();
    cfg_if.cfg_valid = 1'b0;
    for (int i = 0; i < 40; i++) begin
      got = {cfg_if.cfg_ready, led_en, phase, pwm_blue, pwm_green, pwm_red};
      exp = model_out(cyc);
      total++;
      if (got !== exp) $display("FAIL hs_after cyc=%0d got=%b required=%b", cyc, got, exp);
      else passed++;
      step();
    end
  endtask

  task automatic test_blink();
    logic [5:0] got, exp;
    do_config(2, 8, 8, 8);
    for (int i = 0; i < 80; i++) begin
      step();
      got = {cfg_if.cfg_ready, led_en, phase, pwm_blue, pwm_green, pwm_red};
      exp = model_out(cyc);
      total++;
      if (got !== exp) $display("FAIL blink cyc=%0d got=%b required=%b", cyc, got, exp);
      else passed++;
    end
  endtask

  task automatic test_breathe();
    logic [5:0] got, exp;
    do_config(3, 15, $urandom_range(15), $urandom_range(15));
    for (int i = 0; i < 270; i++) begin
      step();
      got = {cfg_if.cfg_ready, led_en, phase, pwm_blue, pwm_green, pwm_red};
      exp = model_out(cyc);
      total++;
      if (got !== exp) $display("FAIL breathe cyc=%0d got=%b required=%b", cyc, got, exp);
      else passed++;
    end
  endtask

  task automatic test_back_to_back();
    logic [5:0] got, exp;
    wait_cnt(15);
    do_config($urandom_range(3), $urandom_range(15), $urandom_range(15), $urandom_range(15));
    got = {cfg_if.cfg_ready, led_en, phase, pwm_blue, pwm_green, pwm_red};
    exp = model_out(cyc);
    total++;
    if (got !== exp || cfg_if.cfg_ready !== 1'b1)
      $display("FAIL b2b_coincide cyc=%0d got=%b required=%b", cyc, got, exp);
    else passed++;
    do_config($urandom_range(1, 3), $urandom_range(15), $urandom_range(15), $urandom_range(15));
    for (int i = 0; i < 60; i++) begin
      got = {cfg_if.cfg_ready, led_en, phase, pwm_blue, pwm_green, pwm_red};
      exp = model_out(cyc);
      total++;
      if (got !== exp) $display("FAIL b2b cyc=%0d got=%b required=%b", cyc, got, exp);
      else passed++;
      step();
    end
  endtask

  task automatic test_random();
    logic [5:0] got, exp;
    for (int it = 0; it < 6; it++) begin
      repeat ($urandom_range(20)) step();
      do_config($urandom_range(3), $urandom_range(15), $urandom_range(15), $urandom_range(15));
      for (int i = 0; i < 130; i++) begin
        got = {cfg_if.cfg_ready, led_en, phase, pwm_blue, pwm_green, pwm_red};
        exp = model_out(cyc);
        total++;
        if (got !== exp) $display("FAIL random it=%0d cyc=%0d got=%b required=%b", it, cyc, got, exp);
        else passed++;
        step();
      end
    end
  endtask

  task automatic test_mid_reset();
    logic [5:0] got, exp;
    do_config(3, 15, 9, 4);
    repeat (50) step();
    wait_cnt(2);
    do_config(1, 15, 15, 15);
    for (int i = 0; i < 3; i++) begin
      got = {cfg_if.cfg_ready, led_en, phase, pwm_blue, pwm_green, pwm_red};
      exp = model_out(cyc);
      total++;
      if (got !== exp) $display("FAIL pre_reset cyc=%0d got=%b required=%b", cyc, got, exp);
      else passed++;
      step();
    end
    rst_n = 1'b0;
    sched.delete();
    #1;
    got = {cfg_if.cfg_ready, led_en, phase, pwm_blue, pwm_green, pwm_red};
    total++;
    if (got !== 6'b100000) $display("FAIL async_reset got=%b required=100000", got);
    else passed++;
    repeat (3) step();
    @(negedge hw_clk);
    rst_n = 1'b1;
    for (int i = 0; i < 40; i++) begin
      step();
      got = {cfg_if.cfg_ready, led_en, phase, pwm_blue, pwm_green, pwm_red};
      exp = model_out(cyc);
      total++;
      if (got !== exp) $display("FAIL post_reset cyc=%0d got=%b required=%b", cyc, got, exp);
      else passed++;
    end
  endtask

  initial begin
    cfg_if.cfg_valid = 1'b0;
    cfg_if.cfg_mode  = '0;
    cfg_if.cfg_red   = '0;
    cfg_if.cfg_green = '0;
    cfg_if.cfg_blue  = '0;
    test_reset();
    test_solid();
    test_handshake();
    test_blink();
    test_breathe();
    test_back_to_back();
    test_random();
    test_mid_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/rgb_pwm_sequencer.md
Name: rgb_pwm_sequencer

Overview:
- Generates the three per-channel PWM drive signals and the LED-enable signal for the iCE40 RGB LED driver primitive. The driver consumes these signals; this block produces them.
- Supports four colour modes: off, solid, blink and breathe.
- Colour settings arrive over a valid/ready config interface. They are shadowed and take effect only at a PWM period boundary, so a period is never torn.

Parameters:
- PWM_BITS, 8: PWM counter and duty width; one PWM period is 2^PWM_BITS clocks.
- STEP_DIV, 120000: clocks per step tick (10 ms at 12 MHz); must be >= 1.
- BLINK_STEPS, 50: step ticks per blink half-period; must be >= 1.

Ports:
- hw_clk  input  1  system clock (12 MHz HFOSC domain).
- rst_n  input  1  asynchronous active-low reset.
- cfg_valid  input  1  config offer.
- cfg_ready  output  1  config can be accepted.
- cfg_mode  input  2  0=OFF, 1=SOLID, 2=BLINK, 3=BREATHE.
- cfg_red  input  PWM_BITS  red duty.
- cfg_green  input  PWM_BITS  green duty.
- cfg_blue  input  PWM_BITS  blue duty.
- pwm_red  output  1  to driver RGB0PWM.
- pwm_green  output  1  to driver RGB1PWM.
- pwm_blue  output  1  to driver RGB2PWM.
- led_en  output  1  to driver RGBLEDEN/CURREN; 1 when active mode != OFF.
- phase  output  1  blink: 1 in ON half; breathe: 1 while ramping up; 0 otherwise.

Behaviour:
- Clock and reset: single clock hw_clk; reset is asynchronous, active-low on rst_n.
- Reset values: all pwm_*, led_en and phase are 0; cfg_ready=1. Active mode=OFF, duties=0, shadow empty, pwm_cnt=0, step counter=0, level=0, breathe state=RAMP_UP.
- PWM counter: pwm_cnt is PWM_BITS wide, increments every clock and wraps from 2^PWM_BITS-1 to 0.
- Config handshake:
  - A transfer occurs when cfg_valid && cfg_ready.
  - The transfer captures mode and duties into the shadow and drives cfg_ready=0 on the next cycle.
  - Apply point: the cycle where pwm_cnt==2^PWM_BITS-1. On that cycle the shadow copies into the active registers, and cfg_ready returns to 1 on the next cycle.
  - If a transfer and the apply point coincide on the same cycle, the new config is captured and applied together.
  - cfg_valid while cfg_ready=0 is ignored; the master holds the offer.
- On apply: step counter=0, level=0, blink half=ON, breathe state=RAMP_UP. These reset even when the applied mode equals the current mode.
- Step tick: a 1-cycle pulse each time the step counter reaches STEP_DIV-1; the counter then wraps to 0.
- Effective duty eff_x per channel:
  - OFF: 0.
  - SOLID: duty_x.
  - BLINK: duty_x in the ON half, 0 in the OFF half. The half toggles after BLINK_STEPS step ticks.
  - BREATHE: (duty_x * level) >> PWM_BITS, using a full 2*PWM_BITS product and truncating.
- Breathe state machine:
  - RAMP_UP: level+1 per step tick. On the tick that reaches 2^PWM_BITS-1, go to RAMP_DOWN.
  - RAMP_DOWN: level-1 per step tick. On the tick that reaches 0, go to RAMP_UP.
  - level never wraps.
- Outputs:
  - pwm_x is registered as (pwm_cnt < eff_x), giving one cycle of latency from counter to pin.
  - duty=0 gives constant 0; duty=max gives high for 2^PWM_BITS-1 of every 2^PWM_BITS clocks.
  - led_en and phase are registered from the active state.
- Mid-operation reset: all state returns to reset values immediately; a pending shadow is discarded.

Test Plan:
- Bench parameters: PWM_BITS=4, STEP_DIV=4, BLINK_STEPS=2.
- Reset: hold rst_n=0 for 5 clocks, release -> all pwm_*=0, led_en=0, phase=0, cfg_ready=1; remain so for 64 clocks with no config.
- SOLID red=5, green=0, blue=15 -> after apply: red high exactly 5 of every 16 clocks, green constantly 0, blue high 15/16; led_en=1 from the apply point.
- Handshake: offer a config at pwm_cnt=3 -> cfg_ready=0 from the next cycle until the cycle after pwm_cnt=15. A second cfg_valid during that window is not accepted, and outputs keep the old config until the boundary.
- BLINK all duties=8 -> red high 8/16 for 8 clocks (2 ticks × 4), 0 for 8 clocks, repeating. phase follows the halves.
- BREATHE red=15 -> level 0→15 over 15 ticks, then 15→0; red duty=(15*level)>>4, e.g. 14 at level 15. phase=1 while rising, 0 while falling.
- Assert rst_n=0 mid-breathe with a shadow pending -> outputs 0 asynchronously; after release mode=OFF and the pending config is discarded.
